mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator between the CPU datapath and the word-only data memory. Accepts one load or store request per transaction with sign/zero-extended sub-word loads and read-modify-write sub-word stores. Detects misalignment and returns one response per request. Sits in the MEM stage and drives the data memory's write-enable, read-enable, address, data and PC ports.

## Interface
- No parameters; memory word width fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE and not in reset)
- req_op  in  3  operation code (encodings in Structure)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/halfword used for SB/SH
- req_pc  in  32  PC of the instruction, forwarded for memory trace
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_exc  out  1  misaligned-access fault, valid with resp_valid
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_pc  out  32  captured req_pc
- mem_rdata  in  32  word read data, combinational in the same cycle as mem_re

## Operation
- Handshake: accept when req_valid && req_ready. Capture op, addr, wdata and pc into registers. Request inputs are ignored outside IDLE.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE on accept:
  - misaligned (LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1) -> RESP with exc=1, no memory access
  - LW/LH/LHU/LB/LBU -> LOAD
  - SW -> WRITE
  - SH/SB -> RMW_RD
- LOAD: mem_re=1. At the edge, register the extracted lane into rdata. Lane = addr[1:0] for bytes, addr[1] for halves. LB/LH sign-extend; LBU/LHU zero-extend. Next state RESP.
- RMW_RD: mem_re=1. At the edge, register mem_rdata with the addressed byte/halfword replaced by wdata[7:0]/wdata[15:0]; other lanes are unchanged. Next state WRITE.
- WRITE: mem_we=1, mem_wdata = merged word (SH/SB) or captured wdata (SW). Next state RESP.
- RESP: resp_valid=1, resp_rdata/resp_exc from registers. Next state IDLE.
- mem_re, mem_we, mem_addr and mem_wdata are 0 in IDLE and RESP. mem_pc holds its last captured value.
- Only one transaction is in flight; there are no back-to-back overlaps.

## Timing
- Accept at cycle 0. Response cycle:
  - loads, SW: cycle 2
  - SH/SB: cycle 3
  - fault: cycle 1
- Earliest next accept is the cycle after RESP.
- Reset values: state IDLE, all outputs 0, captured registers 0. req_ready rises the first cycle after reset deasserts.
- Reset mid-operation: the transaction is dropped. The FSM returns to IDLE, no resp_valid is produced, and no write is issued. mem_we and mem_re are gated by !reset in the reset cycle itself.
- Within a cycle, mem_rdata is sampled only in LOAD/RMW_RD, on the same edge that leaves the state.

## Structure
- Shared package/header mem_pkg holds:
  - op codes: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7
  - state encodings
  - is_load/is_store/size helpers
- Combinational sub-module mem_lane_mux:
  - input word, addr[1:0], op
  - output extended load value and merged store word
- mem_access_unit holds the FSM and capture registers.

## Test plan
- LW at 0x0000_0010 with mem_rdata=0xDEAD_BEEF:
  - mem_re high in cycle 1, mem_addr=0x10
  - cycle 2: resp_valid, rdata=0xDEAD_BEEF
- LB and LBU at 0x13 with word 0x80FF_1234:
  - LB returns 0xFFFF_FF80; LBU returns 0x0000_0080
  - LH at 0x12 returns 0xFFFF_80FF
- SB at 0x21, wdata=0x0000_00AB, memory word 0x1122_3344:
  - cycle 1 read
  - cycle 2: mem_we, mem_addr=0x20, mem_wdata=0x1122_AB44
  - cycle 3 resp
- Misaligned LW at 0x02 and SH at 0x05:
  - resp at cycle 1, resp_exc=1, rdata=0
  - mem_we and mem_re never asserted
- Reset asserted during WRITE of an SW:
  - mem_we=0 that cycle, no resp_valid
  - req_ready=1 the cycle after reset drops
- SW then LW back-to-back with req_valid held:
  - second accept the cycle after the first RESP
  - LW returns the SW data through a memory model

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes,
// FSM state encoding and small decode helpers.
package mem_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    function automatic logic is_load(mem_op_e op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(mem_op_e op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic mem_size_e op_size(mem_op_e op);
        case (op)
            OP_LW, OP_SW:         return SZ_WORD;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_BYTE;
        endcase
    endfunction

    // A word access needs addr[1:0]==0, a halfword access needs addr[0]==0.
    function automatic logic is_misaligned(mem_op_e op, logic [1:0] addr_lo);
        case (op_size(op))
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
// slave = the unit itself, master = the environment (CPU + memory).
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc,
        output mem_re, mem_we, mem_addr, mem_wdata, mem_pc
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc,
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_pc
    );
endinterface

// File: rtl/mem_lane_mux.sv
// Byte/halfword lane steering: extracts and extends a load lane from a
// memory word, and merges store data into a word for read-modify-write.
module mem_lane_mux
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  mem_op_e     op_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed lane, extend it for loads, and splice store data in.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        byte_lane   = word_i[7:0];
        half_lane   = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        merged_o    = word_i;

        case (addr_lo_i)
            2'd1:    byte_lane = word_i[15:8];
            2'd2:    byte_lane = word_i[23:16];
            2'd3:    byte_lane = word_i[31:24];
            default: byte_lane = word_i[7:0];
        endcase

        case (op_i)
            OP_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_data_o = {24'b0, byte_lane};
            OP_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_data_o = {16'b0, half_lane};
            default: load_data_o = word_i;
        endcase

        case (op_i)
            OP_SW: merged_o = wdata_i;
            OP_SH: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
            end
            OP_SB: begin
                case (addr_lo_i)
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    2'd3:    merged_o[31:24] = wdata_i[7:0];
                    default: merged_o[7:0]   = wdata_i[7:0];
                endcase
            end
            default: merged_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one transaction in flight, sub-word loads
// with extension, sub-word stores by read-modify-write, misalignment faults.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_access_unit_if.slave bus
);

    state_e      state_q, state_d;
    mem_op_e     op_q,    op_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;   // store data, replaced by the merged word in RMW_RD
    logic [31:0] pc_q,    pc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        exc_q,   exc_d;

    logic        accept;
    logic        active;
    mem_op_e     req_op;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_op = mem_op_e'(bus.req_op);
    assign active = !reset;
    assign accept = bus.req_valid && bus.req_ready;

    mem_lane_mux u_lane_mux (
        .word_i      (bus.mem_rdata),
        .addr_lo_i   (addr_q[1:0]),
        .op_i        (op_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged_word)
    );

    // Next-state and capture logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = req_op;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    rdata_d = '0;
                    exc_d   = 1'b0;
                    if (is_misaligned(req_op, bus.req_addr[1:0])) begin
                        exc_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (is_load(req_op)) begin
                        state_d = ST_LOAD;
                    end else if (req_op == OP_SW) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                wdata_d = merged_word;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the current state; all strobes drop in reset.
    always_comb begin
        bus.req_ready  = active && (state_q == ST_IDLE);
        bus.mem_re     = active && (state_q inside {ST_LOAD, ST_RMW_RD});
        bus.mem_we     = active && (state_q == ST_WRITE);
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_pc     = pc_q;
        bus.resp_valid = active && (state_q == ST_RESP);
        bus.resp_rdata = '0;
        bus.resp_exc   = 1'b0;

        if (active && (state_q inside {ST_LOAD, ST_RMW_RD, ST_WRITE})) begin
            bus.mem_addr = {addr_q[31:2], 2'b00};
        end
        if (bus.mem_we) begin
            bus.mem_wdata = wdata_q;
        end
        if (bus.resp_valid) begin
            bus.resp_rdata = rdata_q;
            bus.resp_exc   = exc_q;
        end
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a
// randomized run against a byte-lane reference model of memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Environment memory (what the DUT actually reads/writes) and the
    // model's idea of what memory should contain.
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];
    assign bus.mem_rdata = env_mem[bus.mem_addr[5:2]];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          lat;
        int          re_cycles;
        int          we_cycles;
        int          first_re;
        int          first_we;
        logic [31:0] re_addr;
        logic [31:0] we_addr;
        logic [31:0] we_data;
        logic [31:0] pc_seen;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int ref_size(mem_op_e op);
        case (op)
            OP_LW, OP_SW:         return 4;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 1;
        endcase
    endfunction

    function automatic logic ref_fault(mem_op_e op, logic [31:0] addr);
        return (addr % ref_size(op)) != 0;
    endfunction

    function automatic int ref_latency(mem_op_e op, logic [31:0] addr);
        if (ref_fault(op, addr)) return 1;
        if (op == OP_SH || op == OP_SB) return 3;
        return 2;
    endfunction

    function automatic logic [31:0] ref_load(mem_op_e op, logic [31:0] addr);
        logic [31:0] w, v;
        w = ref_mem[addr[5:2]];
        v = w >> (8 * (addr % 4));
        case (op)
            OP_LBU: return v & 32'hFF;
            OP_LB:  begin v = v & 32'hFF;   return (v >= 32'h80)   ? v - 32'h100   : v; end
            OP_LHU: return v & 32'hFFFF;
            OP_LH:  begin v = v & 32'hFFFF; return (v >= 32'h8000) ? v - 32'h10000 : v; end
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(mem_op_e op, logic [31:0] addr, logic [31:0] wdata);
        logic [31:0] r;
        int off, sz;
        r   = ref_mem[addr[5:2]];
        off = int'(addr % 4);
        sz  = ref_size(op);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) r[8*i +: 8] = wdata[8*(i-off) +: 8];
        end
        return r;
    endfunction

    // ---------------- stimulus driver ----------------
    // Presents one request in an IDLE cycle, then observes the bus until the
    // response (bounded). Memory writes are applied to env_mem as seen.
    task automatic run_txn(input mem_op_e op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           output obs_t o);
        o.rdata = '0; o.exc = 1'b0; o.lat = 0; o.re_cycles = 0; o.we_cycles = 0;
        o.first_re = 0; o.first_we = 0; o.re_addr = '0; o.we_addr = '0;
        o.we_data = '0; o.pc_seen = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.mem_re) begin
                o.re_cycles++;
                if (o.first_re == 0) o.first_re = c;
                o.re_addr = bus.mem_addr;
                o.pc_seen = bus.mem_pc;
            end
            if (bus.mem_we) begin
                o.we_cycles++;
                if (o.first_we == 0) o.first_we = c;
                o.we_addr = bus.mem_addr;
                o.we_data = bus.mem_wdata;
                o.pc_seen = bus.mem_pc;
                env_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                o.lat   = c;
                o.rdata = bus.resp_rdata;
                o.exc   = bus.resp_exc;
                break;
            end
        end
        if (o.lat == 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout: op=%0d addr=%h got no resp_valid, required within 10 cycles", op, addr);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b required 0", bus.req_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b required 1", bus.req_ready); end
        checks++;
        if ({bus.resp_valid, bus.resp_exc, bus.mem_re, bus.mem_we} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b required 0000", {bus.resp_valid, bus.resp_exc, bus.mem_re, bus.mem_we});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_pc, bus.resp_rdata} !== 128'b0) begin
            errors++; $display("FAIL reset_buses: addr=%h wdata=%h pc=%h rdata=%h required all 0",
                               bus.mem_addr, bus.mem_wdata, bus.mem_pc, bus.resp_rdata);
        end
    endtask

    task automatic test_lw();
        obs_t o;
        env_mem[4] = 32'hDEAD_BEEF;
        run_txn(OP_LW, 32'h10, 32'h0, 32'h0000_1000, o);
        checks++;
        if (o.first_re !== 1 || o.re_cycles !== 1) begin errors++; $display("FAIL lw_re_cycle: first=%0d count=%0d required 1/1", o.first_re, o.re_cycles); end
        checks++;
        if (o.re_addr !== 32'h10) begin errors++; $display("FAIL lw_mem_addr: got %h required 00000010", o.re_addr); end
        checks++;
        if (o.lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", o.lat); end
        checks++;
        if (o.rdata !== 32'hDEAD_BEEF || o.exc !== 1'b0) begin errors++; $display("FAIL lw_rdata: got %h exc=%b required deadbeef exc=0", o.rdata, o.exc); end
        checks++;
        if (o.pc_seen !== 32'h0000_1000) begin errors++; $display("FAIL lw_mem_pc: got %h required 00001000", o.pc_seen); end
    endtask

    task automatic test_sub_loads();
        obs_t o;
        env_mem[4] = 32'h80FF_1234;
        run_txn(OP_LB, 32'h13, 32'h0, 32'h4, o);
        checks++;
        if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sign: got %h required ffffff80", o.rdata); end
        run_txn(OP_LBU, 32'h13, 32'h0, 32'h8, o);
        checks++;
        if (o.rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero: got %h required 00000080", o.rdata); end
        run_txn(OP_LH, 32'h12, 32'h0, 32'hC, o);
        checks++;
        if (o.rdata !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_sign: got %h required ffff80ff", o.rdata); end
    endtask

    task automatic test_sb();
        obs_t o;
        env_mem[8] = 32'h1122_3344;
        run_txn(OP_SB, 32'h21, 32'h0000_00AB, 32'h20, o);
        checks++;
        if (o.first_re !== 1 || o.first_we !== 2) begin errors++; $display("FAIL sb_phases: re@%0d we@%0d required re@1 we@2", o.first_re, o.first_we); end
        checks++;
        if (o.we_addr !== 32'h20 || o.we_data !== 32'h1122_AB44) begin
            errors++; $display("FAIL sb_write: addr=%h data=%h required 00000020/1122ab44", o.we_addr, o.we_data);
        end
        checks++;
        if (o.lat !== 3 || o.rdata !== 32'h0) begin errors++; $display("FAIL sb_resp: lat=%0d rdata=%h required 3/0", o.lat, o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(OP_LW, 32'h02, 32'h0, 32'h30, o);
        checks++;
        if (o.lat !== 1 || o.exc !== 1'b1 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL lw_misaligned: lat=%0d exc=%b rdata=%h required 1/1/0", o.lat, o.exc, o.rdata);
        end
        checks++;
        if (o.re_cycles !== 0 || o.we_cycles !== 0) begin errors++; $display("FAIL lw_misaligned_access: re=%0d we=%0d required 0/0", o.re_cycles, o.we_cycles); end
        run_txn(OP_SH, 32'h05, 32'hFFFF, 32'h34, o);
        checks++;
        if (o.lat !== 1 || o.exc !== 1'b1 || o.rdata !== 32'h0) begin
            errors++; $display("FAIL sh_misaligned: lat=%0d exc=%b rdata=%h required 1/1/0", o.lat, o.exc, o.rdata);
        end
        checks++;
        if (o.re_cycles !== 0 || o.we_cycles !== 0) begin errors++; $display("FAIL sh_misaligned_access: re=%0d we=%0d required 0/0", o.re_cycles, o.we_cycles); end
    endtask

    task automatic test_reset_mid_write();
        int resp_seen = 0;
        int we_seen   = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.req_pc    = 32'h40;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_phase: mem_we=%b required 1", bus.mem_we); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_we_gated: mem_we=%b resp_valid=%b required 0/0", bus.mem_we, bus.resp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b required 1", bus.req_ready); end
        repeat (4) begin
            if (bus.resp_valid) resp_seen++;
            if (bus.mem_we) we_seen++;
            @(negedge clk);
        end
        checks++;
        if (resp_seen !== 0 || we_seen !== 0) begin errors++; $display("FAIL rst_dropped: resp=%0d we=%0d required 0/0", resp_seen, we_seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        int          first_lat = 0;
        int          second_lat = 0;
        logic [31:0] got = '0;
        data = $urandom;
        env_mem[13] = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'h34;
        bus.req_wdata = data;
        bus.req_pc    = 32'h50;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.mem_we) env_mem[bus.mem_addr[5:2]] = bus.mem_wdata;
            if (bus.resp_valid) begin
                first_lat     = c;
                bus.req_op    = OP_LW;
                bus.req_wdata = 32'h0;
                bus.req_pc    = 32'h54;
                break;
            end
        end
        checks++;
        if (first_lat !== 2) begin errors++; $display("FAIL b2b_sw_latency: got %0d required 2", first_lat); end
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: req_ready=%b required 1", bus.req_ready); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                second_lat = c;
                got        = bus.resp_rdata;
                break;
            end
        end
        checks++;
        if (second_lat !== 2 || got !== data) begin
            errors++; $display("FAIL b2b_lw_data: lat=%0d rdata=%h required 2/%h", second_lat, got, data);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        mem_op_e     op;
        logic [31:0] addr, wdata, pc, exp_rdata, exp_word;
        logic        exp_exc;
        int          exp_lat;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        for (int n = 0; n < 80; n++) begin
            op    = mem_op_e'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 63));
            wdata = $urandom;
            pc    = $urandom;
            exp_exc   = ref_fault(op, addr);
            exp_lat   = ref_latency(op, addr);
            exp_rdata = (!exp_exc && ref_size(op) > 0 && op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU})
                        ? ref_load(op, addr) : 32'h0;
            run_txn(op, addr, wdata, pc, o);
            checks++;
            if (o.lat !== exp_lat || o.exc !== exp_exc || o.rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_resp[%0d]: op=%0d addr=%h lat=%0d exc=%b rdata=%h required %0d/%b/%h",
                         n, op, addr, o.lat, o.exc, o.rdata, exp_lat, exp_exc, exp_rdata);
            end
            if (!exp_exc) begin
                checks++;
                if (o.pc_seen !== pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h required %h", n, o.pc_seen, pc); end
            end
            if (!exp_exc && op inside {OP_SW, OP_SH, OP_SB}) begin
                exp_word = ref_store(op, addr, wdata);
                ref_mem[addr[5:2]] = exp_word;
                checks++;
                if (o.we_cycles !== 1 || env_mem[addr[5:2]] !== exp_word) begin
                    errors++;
                    $display("FAIL rand_store[%0d]: op=%0d addr=%h writes=%0d word=%h required 1/%h",
                             n, op, addr, o.we_cycles, env_mem[addr[5:2]], exp_word);
                end
            end else begin
                checks++;
                if (o.we_cycles !== 0) begin errors++; $display("FAIL rand_no_write[%0d]: writes=%0d required 0", n, o.we_cycles); end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_pc    = '0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_lw();
        test_sub_loads();
        test_sb();
        test_misaligned();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
